// File: rtl/dmem_responder.sv
// RV32I data-memory responder: one transaction at a time, byte/half/word sizing from funct3.
// Latency: rsp_valid LATENCY+1 cycles after accept; stalls in RESP until rsp_ready, req_ready low while busy.
// Build option DMEM_MISALIGN_CHECK_EN: fault misaligned half/word accesses instead of aligning them.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  LAT     = LATENCY[3:0];
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        enter_resp;

    logic [31:0] mem_q [DEPTH_WORDS];

    // With zero wait states the access happens on the accepting edge, so it must see the live request.
    logic        op_we;
    logic [31:0] op_addr, op_wdata;
    logic [2:0]  op_f3;
    assign op_we    = (LAT == 4'd0) ? req_we     : we_q;
    assign op_addr  = (LAT == 4'd0) ? req_addr   : addr_q;
    assign op_wdata = (LAT == 4'd0) ? req_wdata  : wdata_q;
    assign op_f3    = (LAT == 4'd0) ? req_funct3 : f3_q;

    logic [31:0]      off, word_off;
    logic             in_range, size_ok, acc_err;
    logic [1:0]       lane;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_word, ld_data, st_data;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [3:0]       st_be;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic             misalign;
`endif

    always_comb begin
        off      = op_addr - BASE_ADDR;
        word_off = off >> 2;
        in_range = (word_off < DEPTH_L);
        idx      = word_off[IDX_W-1:0];

        // Half/word accesses ignore the low address bits below their natural alignment.
        lane = op_addr[1:0];
        case (op_f3[1:0])
            2'b01:   lane = {op_addr[1], 1'b0};
            2'b10:   lane = 2'b00;
            default: lane = op_addr[1:0];
        endcase

        if (op_we) size_ok = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010);
        else       size_ok = (op_f3 == 3'b000) || (op_f3 == 3'b001) || (op_f3 == 3'b010) ||
                             (op_f3 == 3'b100) || (op_f3 == 3'b101);

`ifdef DMEM_MISALIGN_CHECK_EN
        misalign = 1'b0;
        case (op_f3[1:0])
            2'b01:   misalign = op_addr[0];
            2'b10:   misalign = |op_addr[1:0];
            default: misalign = 1'b0;
        endcase
        acc_err = !size_ok || !in_range || misalign;
`else
        acc_err = !size_ok || !in_range;
`endif

        rd_word = mem_q[idx];
        rd_byte = rd_word[8*lane +: 8];
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

        case (op_f3)
            3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, rd_byte};
            3'b101:  ld_data = {16'd0, rd_half};
            default: ld_data = 32'd0;
        endcase

        case (op_f3)
            3'b000: begin
                st_be   = 4'b0001 << lane;
                st_data = {4{op_wdata[7:0]}};
            end
            3'b001: begin
                st_be   = lane[1] ? 4'b1100 : 4'b0011;
                st_data = {2{op_wdata[15:0]}};
            end
            3'b010: begin
                st_be   = 4'b1111;
                st_data = op_wdata;
            end
            default: begin
                st_be   = 4'b0000;
                st_data = 32'd0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    cnt_d   = LAT;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || op_we) ? 32'd0 : ld_data;
        end else if (state_d != RESP) begin
            err_d   = 1'b0;
            rdata_d = 32'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            f3_q        <= 3'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            f3_q        <= f3_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    // Array keeps its contents across reset; a reset clears state_q so no RESP-entry write can follow.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) mem_q[idx][8*b +: 8] <= st_data[8*b +: 8];
            end
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 instance for most steps, LATENCY=0 instance for zero-wait timing.
module tb_dmem_responder;
    logic        clk;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_ready;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;
    logic        m_req_ready, m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;

    int          checks;
    int          errors;
    int          t_lat;
    logic [31:0] t_rd;
    logic        t_er;

    assign a_req_valid = req_valid & ~sel;
    assign b_req_valid = req_valid & sel;
    assign m_req_ready = sel ? b_req_ready : a_req_ready;
    assign m_rsp_valid = sel ? b_rsp_valid : a_rsp_valid;
    assign m_rsp_rdata = sel ? b_rsp_rdata : a_rsp_rdata;
    assign m_rsp_err   = sel ? b_rsp_err   : a_rsp_err;

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a request, wait for acceptance, then count cycles until rsp_valid (accept edge = 1).
    task automatic issue(input logic s, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        int n;
        sel        = s;
        req_we     = we;
        req_addr   = a;
        req_wdata  = wd;
        req_funct3 = f3;
        req_valid  = 1'b1;
        n = 0;
        while (m_req_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        t_lat = 1;
        while (m_rsp_valid !== 1'b1 && t_lat < 40) begin
            @(posedge clk); #1;
            t_lat++;
        end
        t_rd = m_rsp_rdata;
        t_er = m_rsp_err;
    endtask

    task automatic finish_rsp;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn(input logic s, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3);
        issue(s, we, a, wd, f3);
        finish_rsp();
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;
        rsp_ready  = 1'b0;

        #3;
        chk("reset_outs_l2", {29'd0, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata}, 64'd0);
        chk("reset_outs_l0", {29'd0, b_req_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata}, 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", {63'd0, a_req_ready}, 64'd1);

        do_txn(0, 1, 32'h10, 32'hDEADBEEF, 3'b010);
        chk("sw_lat", 64'(t_lat), 64'd3);
        chk("sw_err", {63'd0, t_er}, 64'd0);
        chk("sw_rdata", {32'd0, t_rd}, 64'd0);
        do_txn(0, 0, 32'h10, 32'h0, 3'b010);
        chk("lw_lat", 64'(t_lat), 64'd3);
        chk("lw_rdata", {32'd0, t_rd}, 64'hDEADBEEF);
        chk("lw_err", {63'd0, t_er}, 64'd0);

        do_txn(0, 1, 32'h20, 32'h0, 3'b010);
        do_txn(0, 1, 32'h21, 32'h0000_0080, 3'b000);
        do_txn(0, 0, 32'h20, 32'h0, 3'b010);
        chk("sb_lw", {32'd0, t_rd}, 64'h0000_8000);
        do_txn(0, 0, 32'h21, 32'h0, 3'b000);
        chk("lb_sext", {32'd0, t_rd}, 64'hFFFF_FF80);
        do_txn(0, 0, 32'h21, 32'h0, 3'b100);
        chk("lbu_zext", {32'd0, t_rd}, 64'h0000_0080);
        do_txn(0, 0, 32'h20, 32'h0, 3'b001);
        chk("lh_sext", {32'd0, t_rd}, 64'hFFFF_8000);
        do_txn(0, 1, 32'h22, 32'h1234_ABCD, 3'b001);
        do_txn(0, 1, 32'h23, 32'h0000_007F, 3'b000);
        do_txn(0, 0, 32'h20, 32'h0, 3'b010);
        chk("sh_sb_lw", {32'd0, t_rd}, 64'h7FCD_8000);
        do_txn(0, 0, 32'h22, 32'h0, 3'b101);
        chk("lhu_hi", {32'd0, t_rd}, 64'h0000_7FCD);
        do_txn(0, 0, 32'h23, 32'h0, 3'b000);
        chk("lb_lane3", {32'd0, t_rd}, 64'h0000_007F);

        issue(0, 0, 32'h10, 32'h0, 3'b010);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {63'd0, m_rsp_valid}, 64'd1);
            chk("bp_rdata", {32'd0, m_rsp_rdata}, 64'hDEADBEEF);
            chk("bp_ready", {63'd0, m_req_ready}, 64'd0);
        end
        finish_rsp();
        chk("bp_rel_valid", {63'd0, m_rsp_valid}, 64'd0);
        chk("bp_rel_ready", {63'd0, m_req_ready}, 64'd1);
        do_txn(0, 0, 32'h20, 32'h0, 3'b010);
        chk("bp_next_lat", 64'(t_lat), 64'd3);
        chk("bp_next_rdata", {32'd0, t_rd}, 64'h7FCD_8000);

        do_txn(0, 1, 32'h0, 32'h55AA_55AA, 3'b010);
        do_txn(0, 1, 32'h1000, 32'h1234_5678, 3'b010);
        chk("oor_sw_err", {63'd0, t_er}, 64'd1);
        do_txn(0, 0, 32'h0, 32'h0, 3'b010);
        chk("oor_sw_nowrite", {32'd0, t_rd}, 64'h55AA_55AA);
        do_txn(0, 1, 32'h0, 32'hFFFF_FFFF, 3'b011);
        chk("bad_st_err", {63'd0, t_er}, 64'd1);
        do_txn(0, 0, 32'h0, 32'h0, 3'b010);
        chk("bad_st_nowrite", {32'd0, t_rd}, 64'h55AA_55AA);
        do_txn(0, 0, 32'h1000, 32'h0, 3'b010);
        chk("oor_lw", {31'd0, t_er, t_rd}, {31'd0, 1'b1, 32'h0});
        do_txn(0, 0, 32'h10, 32'h0, 3'b011);
        chk("f3_011_ld", {31'd0, t_er, t_rd}, {31'd0, 1'b1, 32'h0});
        do_txn(0, 0, 32'h10, 32'h0, 3'b110);
        chk("f3_110_ld", {31'd0, t_er, t_rd}, {31'd0, 1'b1, 32'h0});

        do_txn(0, 1, 32'h10, 32'h1122_3344, 3'b010);
        do_txn(0, 0, 32'h12, 32'h0, 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_lw", {31'd0, t_er, t_rd}, {31'd0, 1'b1, 32'h0});
`else
        chk("mis_lw", {31'd0, t_er, t_rd}, {31'd0, 1'b0, 32'h1122_3344});
`endif
        do_txn(0, 0, 32'h21, 32'h0, 3'b001);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_lh", {31'd0, t_er, t_rd}, {31'd0, 1'b1, 32'h0});
`else
        chk("mis_lh", {31'd0, t_er, t_rd}, {31'd0, 1'b0, 32'hFFFF_8000});
`endif
        do_txn(0, 1, 32'h13, 32'h0000_BEEF, 3'b001);
        do_txn(0, 0, 32'h10, 32'h0, 3'b010);
`ifdef DMEM_MISALIGN_CHECK_EN
        chk("mis_sh", {32'd0, t_rd}, 64'h1122_3344);
`else
        chk("mis_sh", {32'd0, t_rd}, 64'hBEEF_3344);
`endif

        do_txn(0, 1, 32'h40, 32'h0, 3'b010);
        sel        = 1'b0;
        req_we     = 1'b1;
        req_addr   = 32'h40;
        req_wdata  = 32'hCAFE_F00D;
        req_funct3 = 3'b010;
        req_valid  = 1'b1;
        for (int n = 0; n < 50 && m_req_ready !== 1'b1; n++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("midrst_outs", {29'd0, a_req_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        do_txn(0, 0, 32'h40, 32'h0, 3'b010);
        chk("midrst_nowrite", {32'd0, t_rd}, 64'h0);
        chk("midrst_err", {63'd0, t_er}, 64'd0);

        do_txn(1, 1, 32'h8, 32'h0BAD_CAFE, 3'b010);
        chk("l0_sw_lat", 64'(t_lat), 64'd1);
        do_txn(1, 0, 32'h8, 32'h0, 3'b010);
        chk("l0_lw_lat", 64'(t_lat), 64'd1);
        chk("l0_lw_rdata", {32'd0, t_rd}, 64'h0BAD_CAFE);
        do_txn(1, 0, 32'hB, 32'h0, 3'b100);
        chk("l0_lbu", {32'd0, t_rd}, 64'h0000_000B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
